// File: rtl/lc3_trace_pkg.sv
`default_nettype none
// ============================================================================
// Package     : lc3_trace_pkg
// Description : Shared constants, record field layout and FSM encoding for
//               the lc3 per-instruction trace recorder.
//               Optional macro LC3_TRACE_TIMESTAMP_EN widens the record with
//               a 32-bit close-edge cycle stamp.
// Revision    : 1.0 - initial release
// ============================================================================
package lc3_trace_pkg;

    localparam logic [5:0]  FETCH_STATE_DEF = 6'd18;
    localparam logic [15:0] HALT_IR_DEF     = 16'hFFFF;

    // Record field offsets (LSB position) and widths
    localparam int MEMDATA_LSB = 0;
    localparam int MEMADDR_LSB = 16;
    localparam int MEMWE_BIT   = 32;
    localparam int REGDATA_LSB = 33;
    localparam int REGWE_BIT   = 49;
    localparam int IR_LSB      = 50;
    localparam int PC_LSB      = 66;
    localparam int WORD_W      = 16;
    localparam int BASE_W      = 82;
    localparam int TS_LSB      = 82;
    localparam int TS_W        = 32;

`ifdef LC3_TRACE_TIMESTAMP_EN
    localparam int REC_W = BASE_W + TS_W;
`else
    localparam int REC_W = BASE_W;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OPEN = 2'd1,
        S_HALT = 2'd2
    } trace_state_t;

endpackage
`default_nettype wire

// File: rtl/trace_fifo.sv
`default_nettype none
// ============================================================================
// Module      : trace_fifo
// Description : First-word fall-through FIFO. The head entry is presented on
//               data_o whenever the FIFO is non-empty (zero otherwise). A push
//               into a full FIFO is taken only if a pop happens on the same
//               edge; a pop from an empty FIFO is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module trace_fifo #(
    parameter int WIDTH = 82,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = empty_o ? '0 : mem_q[rd_q];

    // Accepted operations and next pointer/count values
    always_comb begin
        do_push = push_i && (!full_o || pop_i);
        do_pop  = pop_i && !empty_o;
        wr_d    = do_push ? wr_q + AW'(1) : wr_q;
        rd_d    = do_pop  ? rd_q + AW'(1) : rd_q;
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    // Storage array; contents are don't-care while the count says empty
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= data_i;
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/lc3_trace_capture.sv
`default_nettype none
// ============================================================================
// Module      : lc3_trace_capture
// Description : Per-instruction trace recorder for the lc3 core. Opens a
//               record at the fetch state, accumulates the last register and
//               memory write of the instruction, and pushes the record into a
//               FWFT FIFO when the controller returns to fetch. Retiring
//               HALT_IR stops capture until reset.
//               Optional macro LC3_TRACE_TIMESTAMP_EN appends a 32-bit
//               free-running cycle count as bits [113:82].
// Revision    : 1.0 - initial release
// ============================================================================
module lc3_trace_capture
    import lc3_trace_pkg::*;
#(
    parameter int          DEPTH       = 16,
    parameter logic [5:0]  FETCH_STATE = FETCH_STATE_DEF,
    parameter logic [15:0] HALT_IR     = HALT_IR_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [5:0]             currentState,
    input  logic [5:0]             nextState,
    input  logic [15:0]            pc,
    input  logic [15:0]            instruction,
    input  logic [15:0]            dataBus,
    input  logic [15:0]            mar,
    input  logic [15:0]            mdr,
    input  logic                   ldReg,
    input  logic                   rw,
    output logic [REC_W-1:0]       recData,
    output logic                   recValid,
    input  logic                   recReady,
    output logic                   overflow,
    output logic                   halted,
    output logic [$clog2(DEPTH):0] level
);
    trace_state_t state_q, state_d;
    logic [15:0]  recPC_q, recPC_d;
    logic         regWe_q, regWe_d;
    logic [15:0]  regData_q, regData_d;
    logic         memWe_q, memWe_d;
    logic [15:0]  memAddr_q, memAddr_d;
    logic [15:0]  memData_q, memData_d;
    logic         overflow_q, overflow_d;
    logic         push;
    logic         pop;
    logic         fifo_full;
    logic         fifo_empty;
    logic [REC_W-1:0] rec;

`ifdef LC3_TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q;

    // Free-running cycle stamp, captured into the record at the close edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + TS_W'(1);
        end
    end
`endif

    assign pop      = !fifo_empty && recReady;
    assign recValid = !fifo_empty;
    assign overflow = overflow_q;
    assign halted   = (state_q == S_HALT);

    // Capture FSM: open at fetch, accumulate strobes, close on return to fetch
    always_comb begin
        state_d    = state_q;
        recPC_d    = recPC_q;
        regWe_d    = regWe_q;
        regData_d  = regData_q;
        memWe_d    = memWe_q;
        memAddr_d  = memAddr_q;
        memData_d  = memData_q;
        push       = 1'b0;
        rec        = '0;
        case (state_q)
            S_IDLE: begin
                if (currentState == FETCH_STATE) begin
                    recPC_d   = pc;
                    regWe_d   = 1'b0;
                    regData_d = '0;
                    memWe_d   = 1'b0;
                    memAddr_d = '0;
                    memData_d = '0;
                    state_d   = S_OPEN;
                end
            end
            S_OPEN: begin
                // Strobes of the closing cycle still land in this record
                if (ldReg) begin
                    regWe_d   = 1'b1;
                    regData_d = dataBus;
                end
                if (rw) begin
                    memWe_d   = 1'b1;
                    memAddr_d = mar;
                    memData_d = mdr;
                end
                rec[BASE_W-1:0] = {recPC_q, instruction, regWe_d, regData_d,
                                   memWe_d, memAddr_d, memData_d};
`ifdef LC3_TRACE_TIMESTAMP_EN
                rec[TS_LSB +: TS_W] = ts_q;
`endif
                if ((nextState == FETCH_STATE) && (currentState != FETCH_STATE)) begin
                    if (instruction == HALT_IR) begin
                        state_d = S_HALT;
                    end else begin
                        push    = 1'b1;
                        state_d = S_IDLE;
                    end
                    regWe_d   = 1'b0;
                    regData_d = '0;
                    memWe_d   = 1'b0;
                    memAddr_d = '0;
                    memData_d = '0;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // A full FIFO that is not popping on this edge loses the record
        overflow_d = overflow_q | (push && fifo_full && !pop);
    end

    // Capture state, accumulators and sticky overflow
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            recPC_q    <= '0;
            regWe_q    <= 1'b0;
            regData_q  <= '0;
            memWe_q    <= 1'b0;
            memAddr_q  <= '0;
            memData_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            recPC_q    <= recPC_d;
            regWe_q    <= regWe_d;
            regData_q  <= regData_d;
            memWe_q    <= memWe_d;
            memAddr_q  <= memAddr_d;
            memData_q  <= memData_d;
            overflow_q <= overflow_d;
        end
    end

    trace_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .data_i  (rec),
        .pop_i   (pop),
        .data_o  (recData),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (level)
    );

endmodule
`default_nettype wire

// File: tb/tb_lc3_trace_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_lc3_trace_capture
// Description : Self-checking bench for lc3_trace_capture (DEPTH=4). Expected
//               records are queued when a closing instruction is driven and
//               compared as the consumer pops them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lc3_trace_capture;
    import lc3_trace_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  currentState = '0;
    logic [5:0]  nextState = '0;
    logic [15:0] pc = '0;
    logic [15:0] instruction = '0;
    logic [15:0] dataBus = '0;
    logic [15:0] mar = '0;
    logic [15:0] mdr = '0;
    logic        ldReg = 1'b0;
    logic        rw = 1'b0;
    logic [REC_W-1:0] recData;
    logic        recValid;
    logic        recReady = 1'b0;
    logic        overflow;
    logic        halted;
    logic [$clog2(DEPTH):0] level;

    int passed = 0;
    int total  = 0;
    logic [81:0] exp_q[$];

    typedef struct {
        logic [15:0] pc;
        logic [15:0] ir;
        bit          dec;
        bit          rwe;
        logic [15:0] rv;
        bit          mwe;
        logic [15:0] ma;
        logic [15:0] md;
    } vec_t;

    vec_t tbl[5];

    lc3_trace_capture #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .currentState (currentState),
        .nextState    (nextState),
        .pc           (pc),
        .instruction  (instruction),
        .dataBus      (dataBus),
        .mar          (mar),
        .mdr          (mdr),
        .ldReg        (ldReg),
        .rw           (rw),
        .recData      (recData),
        .recValid     (recValid),
        .recReady     (recReady),
        .overflow     (overflow),
        .halted       (halted),
        .level        (level)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: actual=%h required=%h", nm, act, exp);
        end else begin
            passed++;
        end
    endtask

    function automatic logic [81:0] pack(input logic [15:0] p, input logic [15:0] ir,
                                         input logic rwe, input logic [15:0] rd,
                                         input logic mwe, input logic [15:0] ma,
                                         input logic [15:0] md);
        return {p, ir, rwe, rd, mwe, ma, md};
    endfunction

    // One clock: consumer check at negedge, then model push, then next edge
    task automatic tick(input bit push, input logic [81:0] rec);
        @(negedge clk);
        if (recValid && recReady) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rec", 128'(recData[81:0]), 128'(0));
            end else begin
                chk("rec", 128'(recData[81:0]), 128'(exp_q.pop_front()));
            end
        end
        if (push) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(rec);
        end
        @(posedge clk);
        #1;
    endtask

    // Drive one five-state instruction; last cycle closes the record
    task automatic run_instr(input vec_t v, input bit live, input bit rdy_close);
        logic        e_rwe;
        logic [15:0] e_rd;
        bit          will_push;
        e_rwe     = v.rwe | v.dec;
        e_rd      = v.rwe ? v.rv : (v.dec ? ~v.rv : 16'h0000);
        will_push = live && (v.ir != 16'hFFFF);
        currentState = 6'd18; nextState = 6'd33; pc = v.pc; ldReg = 0; rw = 0;
        tick(0, '0);
        currentState = 6'd33; nextState = 6'd35; pc = v.pc + 16'd1;
        tick(0, '0);
        currentState = 6'd35; nextState = 6'd32; instruction = v.ir;
        tick(0, '0);
        currentState = 6'd32; nextState = 6'd1;
        ldReg = v.dec; dataBus = ~v.rv;
        rw = v.dec && v.mwe; mar = ~v.ma; mdr = ~v.md;
        tick(0, '0);
        currentState = 6'd1; nextState = 6'd18;
        ldReg = v.rwe; dataBus = v.rv; rw = v.mwe; mar = v.ma; mdr = v.md;
        if (rdy_close) recReady = 1'b1;
        tick(will_push, pack(v.pc, v.ir, e_rwe, e_rd, v.mwe,
                             v.mwe ? v.ma : 16'h0, v.mwe ? v.md : 16'h0));
        ldReg = 0; rw = 0;
        if (rdy_close) recReady = 1'b0;
    endtask

    task automatic drain(input string nm);
        recReady = 1'b1;
        currentState = 6'd0; nextState = 6'd0;
        for (int i = 0; i < 20; i++) tick(0, '0);
        chk({nm, "_queue_empty"}, 128'(exp_q.size()), 128'(0));
        chk({nm, "_level0"}, 128'(level), 128'(0));
        recReady = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        currentState = 6'd0; nextState = 6'd0;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
    endtask

    function automatic vec_t mk(input logic [15:0] p, input logic [15:0] ir);
        vec_t v;
        v.pc = p; v.ir = ir; v.dec = 0; v.rwe = 1; v.rv = p ^ 16'h5A5A;
        v.mwe = 0; v.ma = 16'h0; v.md = 16'h0;
        return v;
    endfunction

    initial begin
        tbl[0] = '{16'h3000, 16'h1261, 0, 1, 16'h0005, 0, 16'h0000, 16'h0000};
        tbl[1] = '{16'h3001, 16'h340F, 0, 0, 16'h0000, 1, 16'h3010, 16'hBEEF};
        tbl[2] = '{16'h3002, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000};
        tbl[3] = '{16'h3003, 16'h6283, 1, 1, 16'h1234, 0, 16'h0000, 16'h0000};
        tbl[4] = '{16'h3004, 16'h7482, 1, 0, 16'h0000, 1, 16'h4000, 16'hCAFE};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_recValid", 128'(recValid), 128'(0));
        chk("rst_overflow", 128'(overflow), 128'(0));
        chk("rst_halted",   128'(halted),   128'(0));
        chk("rst_level",    128'(level),    128'(0));
        chk("rst_recData",  128'(recData),  128'(0));
        reset = 1'b0;
        #1;

        // Table-driven records with the consumer always ready
        recReady = 1'b1;
        for (int i = 0; i < 5; i++) run_instr(tbl[i], 1, 0);
        drain("table");
        chk("table_overflow", 128'(overflow), 128'(0));

        // Fill, then push with a same-edge pop, then overflow
        do_reset();
        for (int i = 0; i < 4; i++) run_instr(mk(16'h3100 + 16'(i), 16'h1000 + 16'(i)), 1, 0);
        chk("full_level", 128'(level), 128'(4));
        run_instr(mk(16'h3104, 16'h1004), 1, 1);
        chk("pushpop_level", 128'(level), 128'(4));
        chk("pushpop_overflow", 128'(overflow), 128'(0));
        run_instr(mk(16'h3105, 16'h1005), 1, 0);
        run_instr(mk(16'h3106, 16'h1006), 1, 0);
        chk("ovf_level", 128'(level), 128'(4));
        chk("ovf_flag", 128'(overflow), 128'(1));
        drain("ovf");
        chk("ovf_sticky", 128'(overflow), 128'(1));

        // HALT: no record, capture stops, earlier records drain
        do_reset();
        run_instr(mk(16'h3200, 16'h1200), 1, 0);
        run_instr(mk(16'h3201, 16'h1201), 1, 0);
        run_instr(mk(16'h3202, 16'hFFFF), 1, 0);
        chk("halt_flag", 128'(halted), 128'(1));
        chk("halt_level", 128'(level), 128'(2));
        run_instr(mk(16'h3203, 16'h1203), 0, 0);
        chk("halt_ignores", 128'(level), 128'(2));
        drain("halt");
        chk("halt_stays", 128'(halted), 128'(1));

        // Asynchronous reset mid-instruction with three records held
        do_reset();
        for (int i = 0; i < 3; i++) run_instr(mk(16'h3300 + 16'(i), 16'h1300 + 16'(i)), 1, 0);
        chk("pre_rst_level", 128'(level), 128'(3));
        currentState = 6'd18; nextState = 6'd33; pc = 16'h3303;
        tick(0, '0);
        currentState = 6'd33; nextState = 6'd35;
        #2 reset = 1'b1;
        #1;
        chk("arst_recValid", 128'(recValid), 128'(0));
        chk("arst_level",    128'(level),    128'(0));
        chk("arst_recData",  128'(recData),  128'(0));
        chk("arst_halted",   128'(halted),   128'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
        currentState = 6'd0; nextState = 6'd0;
        tick(0, '0);
        run_instr(mk(16'h3400, 16'h1400), 1, 0);
        chk("restart_level", 128'(level), 128'(1));
        drain("restart");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
